// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants, coefficient table, test-tone sine table
//               and state encoding for the nine-tap low-pass FIR filter.
//               Q1.15 coefficients are symmetric and sum to 32768, so the
//               filter has unity DC gain.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int WIDTH    = 16;
    localparam int NUM_TAPS = 9;
    localparam int COEFF_W  = 16;
    localparam int ACC_W    = 36;
    localparam int TONE_LEN = 32;

    localparam logic signed [COEFF_W-1:0] COEFFS [NUM_TAPS] = '{
        16'sd512, 16'sd1536, 16'sd3584, 16'sd6144, 16'sd9216,
        16'sd6144, 16'sd3584, 16'sd1536, 16'sd512
    };

    // One full cycle, amplitude 16000, entry i = round(16000*sin(2*pi*i/32)).
    localparam logic signed [WIDTH-1:0] SINE_TABLE [TONE_LEN] = '{
        16'sd0,      16'sd3121,   16'sd6123,   16'sd8889,
        16'sd11314,  16'sd13304,  16'sd14782,  16'sd15693,
        16'sd16000,  16'sd15693,  16'sd14782,  16'sd13304,
        16'sd11314,  16'sd8889,   16'sd6123,   16'sd3121,
        16'sd0,      -16'sd3121,  -16'sd6123,  -16'sd8889,
        -16'sd11314, -16'sd13304, -16'sd14782, -16'sd15693,
        -16'sd16000, -16'sd15693, -16'sd14782, -16'sd13304,
        -16'sd11314, -16'sd8889,  -16'sd6123,  -16'sd3121
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } fir_state_t;

endpackage
`default_nettype wire

// File: rtl/tone_lut.sv
`default_nettype none
// ============================================================================
// Module      : tone_lut
// Description : Built-in sine test-tone source. Presents the current table
//               entry on sample; each step pulse advances a 5-bit index
//               that wraps 31 -> 0. Index resets to 0.
// Ports       : clk    - system clock
//               rst    - asynchronous active-high reset
//               step   - advance to next table entry
//               sample - current tone sample (signed)
// Revision    : 1.0 - initial release
// ============================================================================
module tone_lut
    import fir_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    step,
    output logic signed [WIDTH-1:0] sample
);

    localparam int c_idx_w = $clog2(TONE_LEN);

    logic [c_idx_w-1:0] r_index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
        end else if (step) begin
            r_index <= r_index + c_idx_w'(1);
        end
    end

    assign sample = SINE_TABLE[r_index];

endmodule
`default_nettype wire

// File: rtl/fir_lowpass_filter.sv
`default_nettype none
// ============================================================================
// Module      : fir_lowpass_filter
// Description : Nine-tap fixed-coefficient signed low-pass FIR. A rising
//               edge on the enable strobe accepts one sample into the delay
//               line and starts a sequential MAC (one tap per clock). The
//               rounded, saturated result is registered on out. A new accept
//               during MAC/WRITE restarts the MAC and drops the old result.
// Ports       : clk       - system clock
//               rst       - asynchronous active-high reset
//               enable    - sample strobe (level; rising edge accepts)
//               data_in   - signed input sample
//               valid_out - sticky, high once NUM_TAPS samples processed
//               out       - signed filtered sample (registered)
// Config      : FIR_TEST_TONE_EN - internal sine source replaces data_in
// Revision    : 1.0 - initial release
// ============================================================================
module fir_lowpass_filter #(
    parameter int WIDTH    = fir_pkg::WIDTH,
    parameter int NUM_TAPS = fir_pkg::NUM_TAPS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] data_in,
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] out
);

    import fir_pkg::*;

    localparam int c_tap_w  = $clog2(NUM_TAPS + 1);
    localparam int c_prod_w = WIDTH + COEFF_W;

    localparam logic [c_tap_w-1:0] c_last_tap  = c_tap_w'(NUM_TAPS - 1);
    localparam logic [c_tap_w-1:0] c_count_max = c_tap_w'(NUM_TAPS);

    // Half an LSB of the Q1.15 product scale, for round-half-up.
    localparam logic signed [ACC_W-1:0] c_round =
        {{(ACC_W-COEFF_W+1){1'b0}}, 1'b1, {(COEFF_W-2){1'b0}}};
    localparam logic signed [ACC_W-1:0] c_out_max =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_out_min =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    fir_state_t               r_state;
    logic                     r_en_d;
    logic                     w_accept;
    logic [c_tap_w-1:0]       r_tap;
    logic [c_tap_w-1:0]       r_count;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [WIDTH-1:0]  r_x [NUM_TAPS];
    logic signed [WIDTH-1:0]  w_sample;

    logic signed [WIDTH-1:0]   w_x_tap;
    logic signed [COEFF_W-1:0] w_c_tap;
    logic [c_prod_w-1:0]       w_x_ext;
    logic [c_prod_w-1:0]       w_c_ext;
    logic [c_prod_w-1:0]       w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_shift;
    logic signed [WIDTH-1:0]   w_result;

    assign w_accept = enable & ~r_en_d;

    // ------------------------------------------------------------------
    // Sample source
    // ------------------------------------------------------------------
`ifdef FIR_TEST_TONE_EN
    logic w_unused_data_in;
    assign w_unused_data_in = ^data_in;

    tone_lut u_tone_lut (
        .clk    (clk),
        .rst    (rst),
        .step   (w_accept),
        .sample (w_sample)
    );
`else
    assign w_sample = data_in;
`endif

    // ------------------------------------------------------------------
    // Delay line: x[0] is the newest sample
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_x[i] <= '0;
            end
        end else if (w_accept) begin
            r_x[0] <= w_sample;
            for (int i = 1; i < NUM_TAPS; i++) begin
                r_x[i] <= r_x[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Tap product. Operands are sign-extended to the full product width so
    // the low c_prod_w bits of the unsigned multiply are the exact signed
    // product.
    // ------------------------------------------------------------------
    assign w_x_tap    = r_x[r_tap];
    assign w_c_tap    = COEFFS[r_tap];
    assign w_x_ext    = {{COEFF_W{w_x_tap[WIDTH-1]}}, w_x_tap};
    assign w_c_ext    = {{WIDTH{w_c_tap[COEFF_W-1]}}, w_c_tap};
    assign w_prod     = w_x_ext * w_c_ext;
    assign w_prod_ext = {{(ACC_W-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};

    // ------------------------------------------------------------------
    // Round half up, rescale out of Q1.15, then saturate
    // ------------------------------------------------------------------
    always_comb begin
        w_sum    = r_acc + c_round;
        w_shift  = w_sum >>> (COEFF_W - 1);
        w_result = w_shift[WIDTH-1:0];
        if (w_shift > c_out_max) begin
            w_result = c_out_max[WIDTH-1:0];
        end else if (w_shift < c_out_min) begin
            w_result = c_out_min[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM, sample counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_en_d    <= 1'b0;
            r_tap     <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            out       <= '0;
            valid_out <= 1'b0;
        end else begin
            r_en_d <= enable;
            if (w_accept) begin
                // An accept in any state restarts the MAC on the new window.
                r_acc   <= '0;
                r_tap   <= '0;
                r_state <= MAC;
                if (r_count != c_count_max) begin
                    r_count <= r_count + c_tap_w'(1);
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    MAC: begin
                        r_acc <= r_acc + w_prod_ext;
                        if (r_tap == c_last_tap) begin
                            r_state <= WRITE;
                        end else begin
                            r_tap <= r_tap + c_tap_w'(1);
                        end
                    end
                    WRITE: begin
                        out <= w_result;
                        if (r_count == c_count_max) begin
                            valid_out <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_lowpass_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_lowpass_filter
// Description : Self-checking bench for fir_lowpass_filter. A reference
//               model keeps the sample window as a plain array and computes
//               the rounded, saturated dot product with integer arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_lowpass_filter;

    localparam int W  = 16;
    localparam int NT = 9;

    logic                clk;
    logic                rst;
    logic                enable;
    logic signed [W-1:0] data_in;
    logic                valid_out;
    logic signed [W-1:0] out;

    int n_checks = 0;
    int n_fails  = 0;

    int mx [NT];
    int m_count;
    int coef [NT]        = '{512, 1536, 3584, 6144, 9216, 6144, 3584, 1536, 512};
    int impulse_exp [10] = '{16, 47, 109, 188, 281, 188, 109, 47, 16, 0};

    fir_lowpass_filter #(
        .WIDTH    (W),
        .NUM_TAPS (NT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data_in   (data_in),
        .valid_out (valid_out),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int i = 0; i < NT; i++) mx[i] = 0;
        m_count = 0;
    endfunction

    function automatic void m_push(input int s);
        for (int i = NT - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = s;
        if (m_count < NT) m_count++;
    endfunction

    function automatic int m_out();
        longint acc;
        acc = 0;
        for (int i = 0; i < NT; i++) acc += longint'(mx[i]) * longint'(coef[i]);
        acc = (acc + 16384) >>> 15;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_out"}, out, m_out());
        check({tag, "_valid"}, valid_out, (m_count >= NT) ? 1 : 0);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    // One clean strobe pulse, then enough clocks for the result to land.
    task automatic send(input int s);
        @(negedge clk);
        data_in = W'(s);
        enable  = 1'b1;
        @(posedge clk);
        m_push(s);
        @(negedge clk);
        enable = 1'b0;
        repeat (11) @(posedge clk);
        #1;
    endtask

    initial begin
        int s;
        int a;
        int b;
        int old_exp;

        rst     = 1'b1;
        enable  = 1'b0;
        data_in = '0;
        m_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out, 0);
        check("reset_valid", valid_out, 0);
        @(negedge clk);
        rst = 1'b0;

        // Impulse response
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 1000 : 0);
            check($sformatf("impulse_%0d", i), out, impulse_exp[i]);
        end
        check("impulse_valid", valid_out, (m_count >= NT) ? 1 : 0);

        // Asynchronous reset in the middle of a MAC
        send(7000);
        check_model("pre_reset");
        @(negedge clk);
        data_in = 16'sd5000;
        enable  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midmac_reset_out", out, 0);
        check("midmac_reset_valid", valid_out, 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NT; i++) begin
            send(0);
            check($sformatf("zero_after_reset_%0d", i), out, 0);
        end
        check("zero_valid", valid_out, 1);

        // Step response with exact valid_out latency on the 9th accept
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        for (int i = 0; i < NT - 1; i++) begin
            send(1000);
            check_model($sformatf("step_%0d", i));
        end
        @(negedge clk);
        data_in = 16'sd1000;
        enable  = 1'b1;
        @(posedge clk);
        m_push(1000);
        @(negedge clk);
        enable = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("step_valid_early", valid_out, 0);
        @(posedge clk);
        #1;
        check("step_valid_rise", valid_out, 1);
        check("step_out", out, 1000);

        // Full scale, both polarities
        for (int i = 0; i < NT; i++) begin
            send(32767);
            check_model($sformatf("fs_pos_%0d", i));
        end
        check("fs_pos_final", out, 32767);
        for (int i = 0; i < NT; i++) begin
            send(-32768);
            check_model($sformatf("fs_neg_%0d", i));
        end
        check("fs_neg_final", out, -32768);

        // enable held high for 20 clocks accepts exactly one sample
        s = rnd_sample();
        @(negedge clk);
        data_in = W'(s);
        enable  = 1'b1;
        @(posedge clk);
        m_push(s);
        repeat (19) @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check_model("hold");
        send(rnd_sample());
        check_model("hold_next");

        // Second rising edge 5 clocks after an accept aborts the MAC
        old_exp = m_out();
        a = rnd_sample();
        b = rnd_sample();
        @(negedge clk);
        data_in = W'(a);
        enable  = 1'b1;
        @(posedge clk);
        m_push(a);
        @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        data_in = W'(b);
        enable  = 1'b1;
        @(posedge clk);
        m_push(b);
        @(negedge clk);
        enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_write_k10", out, old_exp);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_write_k14", out, old_exp);
        @(posedge clk);
        #1;
        check("abort_write_k15", out, m_out());

        // Randomized samples against the model
        for (int i = 0; i < 40; i++) begin
            send(rnd_sample());
            check_model($sformatf("rand_%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
